// File: rtl/reset_sequencer.sv
// Staged reset sequencer: asynchronous assertion, synchronized and stretched release,
// then ordered per-stage bring-up gated by acknowledges, with a sticky ack-timeout fault.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_GAP   = 4,
  parameter int ACK_TIMEOUT = 255,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  sys_ready,
  output logic                  timeout_err,
  output logic [SW-1:0]         err_stage
);

  localparam int CMAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  localparam logic [TW-1:0] TO_LAST    = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_SYNC     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_GAP      = 3'd3,
    ST_READY    = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   rst_sync;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [TW-1:0]          tcnt, tcnt_nxt;
  logic [SW-1:0]          stage, stage_nxt;
  logic                   ack_cur;
  logic                   soft_hit;
  logic [NUM_STAGES-1:0]  rel_mask;
  logic [NUM_STAGES-1:0]  rst_n_nxt;
  logic                   ready_nxt;
  logic                   err_nxt;
  logic [SW-1:0]          err_stage_nxt;

  // Deassertion synchronizer: asserted asynchronously, released through SYNC_STAGES flops.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_chain[SYNC_STAGES-1];
  assign soft_hit = sw_reset_req && (state != ST_SYNC);

  // Ack of the stage currently being waited on; all other acks are ignored.
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      ack_cur = ack_cur | (stage_ack[i] && (stage == SW'(i)));
    end
  end

  // State and counters register.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_SYNC;
      cnt         <= '0;
      tcnt        <= '0;
      stage       <= '0;
      stage_rst_n <= '0;
      sys_ready   <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tcnt        <= tcnt_nxt;
      stage       <= stage_nxt;
      stage_rst_n <= rst_n_nxt;
      sys_ready   <= ready_nxt;
      timeout_err <= err_nxt;
      err_stage   <= err_stage_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    stage_nxt = stage;
    if (soft_hit) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
      tcnt_nxt  = '0;
      stage_nxt = '0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (rst_sync) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_SYNC;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = ST_WAIT_ACK;
            stage_nxt = '0;
            tcnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_WAIT_ACK: begin
          // A late ack on the expiry edge still wins over the timeout.
          if (ack_cur) begin
            if (stage == LAST_STAGE) begin
              state_nxt = ST_READY;
            end else if (STAGE_GAP == 0) begin
              stage_nxt = stage + SW'(1);
              tcnt_nxt  = '0;
            end else begin
              state_nxt = ST_GAP;
              cnt_nxt   = '0;
            end
          end else if ((ACK_TIMEOUT != 0) && (tcnt == TO_LAST)) begin
            state_nxt = ST_FAULT;
          end else if (ACK_TIMEOUT != 0) begin
            tcnt_nxt = tcnt + TW'(1);
          end else begin
            tcnt_nxt = '0;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt = ST_WAIT_ACK;
            stage_nxt = stage + SW'(1);
            tcnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_READY: state_nxt = ST_READY;
        ST_FAULT: state_nxt = ST_FAULT;
        default: begin
          state_nxt = ST_SYNC;
          cnt_nxt   = '0;
          tcnt_nxt  = '0;
          stage_nxt = '0;
        end
      endcase
    end
  end

  // Output next values: a stage is released on the edge that enters its ack wait.
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      rel_mask[i] = (state_nxt == ST_WAIT_ACK) && (stage_nxt == SW'(i));
    end
    if (soft_hit) begin
      rst_n_nxt = '0;
    end else begin
      rst_n_nxt = stage_rst_n | rel_mask;
    end
    ready_nxt     = (state_nxt == ST_READY);
    err_nxt       = (state_nxt == ST_FAULT);
    err_stage_nxt = (state_nxt == ST_FAULT) ? stage_nxt : '0;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: three instances (defaults, short timeout,
// single stage) driven from one clock and reset, checked edge by edge.
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       sw0, sw1, sw2;
  logic [2:0] a0, a1;

  logic [2:0] rst0, rst1;
  logic       rdy0, rdy1, to0, to1;
  logic [1:0] es0, es1;
  logic [0:0] rst2;
  logic       rdy2, to2;
  logic [0:0] es2;

  int checks = 0;
  int errors = 0;

  reset_sequencer u0 (
    .sys_clk(clk), .reset(reset), .sw_reset_req(sw0), .stage_ack(a0),
    .stage_rst_n(rst0), .sys_ready(rdy0), .timeout_err(to0), .err_stage(es0)
  );

  reset_sequencer #(.ACK_TIMEOUT(4)) u1 (
    .sys_clk(clk), .reset(reset), .sw_reset_req(sw1), .stage_ack(a1),
    .stage_rst_n(rst1), .sys_ready(rdy1), .timeout_err(to1), .err_stage(es1)
  );

  reset_sequencer #(.NUM_STAGES(1), .STAGE_GAP(0), .HOLD_CYCLES(1)) u2 (
    .sys_clk(clk), .reset(reset), .sw_reset_req(sw2), .stage_ack(1'b1),
    .stage_rst_n(rst2), .sys_ready(rdy2), .timeout_err(to2), .err_stage(es2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp3(input int e, input int r0, input int r1, input int r2);
    exp3 = {(e >= r2), (e >= r1), (e >= r0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Nominal bring-up from E1; u1 sees its stage-0 ack only at its 4th sample (E23).
  task automatic run_nominal();
    a0 = 3'b111;
    a1 = 3'b110;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 22) a1 = 3'b111;
      check("u0_rst", 32'(rst0), 32'(exp3(e, 19, 24, 29)));
      check("u0_rdy", 32'(rdy0), 32'(e >= 30));
      check("u0_to",  32'(to0),  32'(0));
      check("u1_rst", 32'(rst1), 32'(exp3(e, 19, 27, 32)));
      check("u1_rdy", 32'(rdy1), 32'(e >= 33));
      check("u1_to",  32'(to1),  32'(0));
      check("u2_rst", 32'(rst2), 32'(e >= 4));
      check("u2_rdy", 32'(rdy2), 32'(e >= 5));
    end
  endtask

  initial begin
    reset = 1'b0;
    sw0 = 1'b0; sw1 = 1'b0; sw2 = 1'b0;
    a0 = 3'b000; a1 = 3'b000;
    repeat (3) tick();
    check("rst_rst0", 32'(rst0), 32'(0));
    check("rst_rdy0", 32'(rdy0), 32'(0));
    check("rst_to0",  32'(to0),  32'(0));
    check("rst_es0",  32'(es0),  32'(0));
    check("rst_rst2", 32'(rst2), 32'(0));
    reset = 1'b1;
    run_nominal();

    // Soft reset from READY: cleared on the sampling edge, sequence restarts from HOLD.
    sw0 = 1'b1;
    tick();
    sw0 = 1'b0;
    check("sw_rst0", 32'(rst0), 32'(0));
    check("sw_rdy0", 32'(rdy0), 32'(0));
    for (int d = 1; d <= 30; d++) begin
      tick();
      check("sw_seq_rst0", 32'(rst0), 32'(exp3(d, 16, 21, 26)));
      check("sw_seq_rdy0", 32'(rdy0), 32'(d >= 27));
      check("sw_u1_rdy",   32'(rdy1), 32'(1));
    end

    // Sub-cycle reset pulse while u0 is in GAP after stage 0 was accepted.
    sw0 = 1'b1;
    tick();
    sw0 = 1'b0;
    for (int d = 1; d <= 18; d++) tick();
    check("gap_pre_rst0", 32'(rst0), 32'(3'b001));
    #3;
    reset = 1'b0;
    #1;
    check("async_rst0", 32'(rst0), 32'(0));
    check("async_rdy0", 32'(rdy0), 32'(0));
    check("async_rst1", 32'(rst1), 32'(0));
    check("async_rdy1", 32'(rdy1), 32'(0));
    check("async_rst2", 32'(rst2), 32'(0));
    #1;
    reset = 1'b1;
    run_nominal();

    // Timeout: u0 stage 1 never acks, u1 stage 0 never acks.
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    a0 = 3'b101;
    a1 = 3'b000;
    for (int e = 1; e <= 300; e++) begin
      tick();
      check("to_rst0", 32'(rst0), 32'(exp3(e, 19, 24, 100000)));
      check("to_err0", 32'(to0),  32'(e >= 279));
      check("to_es0",  32'(es0),  32'((e >= 279) ? 1 : 0));
      check("to_rdy0", 32'(rdy0), 32'(0));
      check("to_rst1", 32'(rst1), 32'(e >= 19));
      check("to_err1", 32'(to1),  32'(e >= 23));
      check("to_es1",  32'(es1),  32'(0));
      check("to_rdy1", 32'(rdy1), 32'(0));
    end

    // Soft reset leaves FAULT and clears the sticky error.
    sw0 = 1'b1;
    sw1 = 1'b1;
    tick();
    sw0 = 1'b0;
    sw1 = 1'b0;
    check("clr_err0", 32'(to0),  32'(0));
    check("clr_es0",  32'(es0),  32'(0));
    check("clr_rst0", 32'(rst0), 32'(0));
    check("clr_err1", 32'(to1),  32'(0));
    check("clr_rst1", 32'(rst1), 32'(0));
    for (int d = 1; d <= 16; d++) tick();
    check("clr_rel0", 32'(rst0), 32'(3'b001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
